// File: rtl/spi_pkg.sv
// spi_pkg: shared widths, defaults and sequencer state encoding.
package spi_pkg;
   localparam int BYTE_W = 8;
   localparam int DIV_W = 16;
   localparam int SPI_DEFAULT_CLK_DIV = 4;
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_GAP   = 2'd3
   } state_t;
endpackage

// File: rtl/spi_byte_fifo.sv
// spi_byte_fifo: synchronous first-word-fall-through FIFO with occupancy level.
module spi_byte_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic do_push, do_pop;
   assign full = level == (AW+1)'(DEPTH);
   assign empty = level == '0;
   assign do_push = push && !full;
   assign do_pop = pop && !empty;
   assign dout = mem[rd_ptr];
   always_ff @(posedge clk)
      if (do_push) mem[wr_ptr] <= din;
   always_ff @(posedge clk)
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(do_push);
         rd_ptr <= rd_ptr + AW'(do_pop);
         level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
endmodule

// File: rtl/spi_txn_sequencer.sv
// spi_txn_sequencer: feeds spi_master one byte per start handshake from a TX FIFO,
// collects replies into an RX FIFO, with inter-byte gap, timeout and burst irq.
module spi_txn_sequencer
   import spi_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int DEFAULT_CLK_DIV = SPI_DEFAULT_CLK_DIV,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          enable,
   input  logic [DIV_W-1:0]              clk_div_cfg,
   input  logic [7:0]                    gap_cfg,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   input  logic [BYTE_W-1:0]             tx_data,
   output logic                          rx_valid,
   input  logic                          rx_ready,
   output logic [BYTE_W-1:0]             rx_data,
   output logic [$clog2(FIFO_DEPTH):0]   tx_level,
   output logic [$clog2(FIFO_DEPTH):0]   rx_level,
   output logic                          busy,
   output logic                          timeout_err,
   input  logic                          err_clr,
   output logic                          irq_done,
   output logic                          m_start,
   output logic [BYTE_W-1:0]             m_tx_data,
   output logic [DIV_W-1:0]              m_clk_div,
   input  logic [BYTE_W-1:0]             m_rx_data,
   input  logic                          m_busy,
   input  logic                          m_done
);
   state_t state;
   logic [15:0] cnt;
   logic [BYTE_W-1:0] tx_head;
   logic tx_full, tx_empty, rx_full, rx_empty;
   logic tx_push, launch, rx_push, to_hit;
   assign tx_ready = !tx_full;
   assign rx_valid = !rx_empty;
   assign tx_push = tx_valid && tx_ready;
   assign launch = state == S_IDLE && enable && !tx_empty && !rx_full;
   assign rx_push = state == S_WAIT && m_done;
   assign to_hit = {1'b0, cnt} + 17'd1 >= 17'(TIMEOUT_CYCLES);
   assign busy = state != S_IDLE;
   spi_byte_fifo #(.WIDTH(BYTE_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk(clk), .reset(reset), .push(tx_push), .din(tx_data), .pop(launch),
      .dout(tx_head), .full(tx_full), .empty(tx_empty), .level(tx_level)
   );
   spi_byte_fifo #(.WIDTH(BYTE_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk(clk), .reset(reset), .push(rx_push), .din(m_rx_data), .pop(rx_ready),
      .dout(rx_data), .full(rx_full), .empty(rx_empty), .level(rx_level)
   );
   always_ff @(posedge clk)
      if (reset) begin
         state <= S_IDLE;
         cnt <= '0;
         m_start <= 1'b0;
         m_tx_data <= '0;
         m_clk_div <= DIV_W'(DEFAULT_CLK_DIV);
         timeout_err <= 1'b0;
         irq_done <= 1'b0;
      end else begin
         irq_done <= 1'b0;
         if (err_clr) timeout_err <= 1'b0;
         case (state)
            S_IDLE:
               if (launch) begin
                  state <= S_ISSUE;
                  cnt <= '0;
                  m_tx_data <= tx_head;
                  m_clk_div <= clk_div_cfg == '0 ? DIV_W'(DEFAULT_CLK_DIV) : clk_div_cfg;
               end
            S_ISSUE:
               if (to_hit) begin
                  timeout_err <= 1'b1;
                  m_start <= 1'b0;
                  cnt <= 16'(gap_cfg);
                  state <= S_GAP;
               end else if (m_busy) begin
                  m_start <= 1'b0;
                  cnt <= cnt + 16'd1;
                  state <= S_WAIT;
               end else begin
                  m_start <= 1'b1;
                  cnt <= cnt + 16'd1;
               end
            S_WAIT:
               // a completed byte wins over a timeout landing on the same cycle
               if (m_done) begin
                  irq_done <= tx_empty && !tx_push;
                  cnt <= 16'(gap_cfg);
                  state <= S_GAP;
               end else if (to_hit) begin
                  timeout_err <= 1'b1;
                  cnt <= 16'(gap_cfg);
                  state <= S_GAP;
               end else
                  cnt <= cnt + 16'd1;
            default:
               if (cnt != '0) cnt <= cnt - 16'd1;
               else if (!m_busy) state <= S_IDLE;
         endcase
      end
endmodule

// File: tb/tb_spi_txn_sequencer.sv
// tb_spi_txn_sequencer: scoreboard bench with a behavioural spi_master model.
module tb_spi_txn_sequencer;
   logic clk = 0, reset = 1, enable = 0;
   logic [15:0] clk_div_cfg = 0;
   logic [7:0] gap_cfg = 0;
   logic tx_valid = 0, tx_ready;
   logic [7:0] tx_data = 0;
   logic rx_valid, rx_ready = 0;
   logic [7:0] rx_data;
   logic [3:0] tx_level, rx_level;
   logic busy, timeout_err, err_clr = 0, irq_done, m_start;
   logic [7:0] m_tx_data, m_rx_data;
   logic [15:0] m_clk_div;
   logic m_busy, m_done;
   spi_txn_sequencer #(.FIFO_DEPTH(8), .DEFAULT_CLK_DIV(4), .TIMEOUT_CYCLES(100)) dut (
      .clk(clk), .reset(reset), .enable(enable), .clk_div_cfg(clk_div_cfg), .gap_cfg(gap_cfg),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
      .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
      .tx_level(tx_level), .rx_level(rx_level), .busy(busy), .timeout_err(timeout_err),
      .err_clr(err_clr), .irq_done(irq_done), .m_start(m_start), .m_tx_data(m_tx_data),
      .m_clk_div(m_clk_div), .m_rx_data(m_rx_data), .m_busy(m_busy), .m_done(m_done)
   );
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;
   int checks = 0, errors = 0;
   logic [23:0] exp_start[$];
   logic [7:0] exp_rx[$];
   int exp_irq[$];
   int hs_cyc = 0, start_cyc = 0, done_cyc = -1, done_cnt = 0;
   bit gap_chk = 0, hang = 0;
   task automatic check(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask
   // master model: accepts start when idle, replies tx^0x99 after 40 cycles, or hangs
   initial begin
      int mcnt;
      logic [7:0] mtx;
      m_busy = 0; m_done = 0; m_rx_data = 0; mcnt = 0; mtx = 0;
      forever begin
         @(posedge clk); #1;
         m_done = 0;
         if (reset) m_busy = 0;
         else if (m_busy) begin
            mcnt++;
            if (hang && mcnt == 150) begin m_busy = 0; hang = 0; end
            else if (!hang && mcnt == 40) begin m_done = 1; m_rx_data = mtx ^ 8'h99; m_busy = 0; end
         end else if (m_start) begin
            m_busy = 1; mtx = m_tx_data; mcnt = 0;
         end
      end
   end
   // monitor: pops expectations whenever the DUT presents an event
   initial begin
      bit prev_start, prev_to;
      logic [23:0] e;
      prev_start = 0; prev_to = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_start = 0; prev_to = 0;
         end else begin
            if (m_start && !prev_start) begin
               if (gap_chk && done_cyc >= 0) begin
                  check("gap_min", int'(cyc - done_cyc >= int'(gap_cfg) + 1), 1);
                  check("gap_max", int'(cyc - done_cyc <= int'(gap_cfg) + 4), 1);
               end
               start_cyc = cyc;
               if (exp_start.size() == 0) check("start_unexpected", 1, 0);
               else begin
                  e = exp_start.pop_front();
                  check("m_tx_data", m_tx_data, e[23:16]);
                  check("m_clk_div", m_clk_div, e[15:0]);
               end
            end
            prev_start = m_start;
            if (m_done) begin done_cnt++; done_cyc = cyc; end
            if (rx_valid && rx_ready) begin
               if (exp_rx.size() == 0) check("rx_unexpected", 1, 0);
               else check("rx_data", rx_data, exp_rx.pop_front());
            end
            if (irq_done) begin
               if (exp_irq.size() == 0) check("irq_unexpected", 1, 0);
               else check("irq_done_index", done_cnt, exp_irq.pop_front());
            end
            if (timeout_err && !prev_to) check("timeout_lat", int'(cyc - start_cyc inside {[99:100]}), 1);
            prev_to = timeout_err;
         end
      end
   end
   task automatic tick(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic push(logic [7:0] d, logic [15:0] div, bit has_rx);
      int n = 0;
      exp_start.push_back({d, div});
      if (has_rx) exp_rx.push_back(d ^ 8'h99);
      tx_data = d; tx_valid = 1;
      @(negedge clk);
      while (!tx_ready && n < 2000) begin @(negedge clk); n++; end
      if (n >= 2000) check("push_stall", 0, 1);
      @(posedge clk); #1;
      hs_cyc = cyc;
      tx_valid = 0;
   endtask
   task automatic wait_drain(string name, int budget);
      int n = 0;
      while (!(exp_start.size() == 0 && exp_irq.size() == 0 && (!rx_ready || exp_rx.size() == 0) && !busy)
             && n < budget) begin
         @(negedge clk); n++;
      end
      check(name, int'(n < budget), 1);
      tick(1);
   endtask
   task automatic wait_start(string name);
      int n = 0;
      while (exp_start.size() != 0 && n < 500) begin @(negedge clk); n++; end
      check(name, int'(n < 500), 1);
      tick(1);
   endtask
   task automatic check_reset_outputs(string tag);
      check({tag, "_tx_ready"}, tx_ready, 1);
      check({tag, "_rx_valid"}, rx_valid, 0);
      check({tag, "_tx_level"}, tx_level, 0);
      check({tag, "_rx_level"}, rx_level, 0);
      check({tag, "_m_start"}, m_start, 0);
      check({tag, "_m_tx_data"}, m_tx_data, 0);
      check({tag, "_m_clk_div"}, m_clk_div, 4);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_timeout_err"}, timeout_err, 0);
      check({tag, "_irq_done"}, irq_done, 0);
   endtask
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end
   initial begin
      int n;
      tick(3);
      check_reset_outputs("rst");
      reset = 0;
      tick(2);
      // single byte A5 -> 3C, divider default
      enable = 1;
      push(8'hA5, 16'd4, 0);
      exp_rx.push_back(8'h3C);
      exp_irq.push_back(1);
      wait_start("single_start");
      check("start_latency", start_cyc - hs_cyc, 2);
      wait_drain("single_done", 500);
      check("single_rx_level", rx_level, 1);
      check("single_rx_valid", rx_valid, 1);
      check("single_rx_head", rx_data, 8'h3C);
      rx_ready = 1;
      wait_drain("single_rx", 50);
      check("single_rx_empty", rx_level, 0);
      // burst of four with gap 5
      gap_cfg = 5; clk_div_cfg = 7; done_cyc = -1; gap_chk = 1;
      for (int i = 1; i <= 4; i++) push(8'(i), 16'd7, 1);
      exp_irq.push_back(5);
      wait_drain("burst_done", 1000);
      gap_chk = 0;
      check("burst_done_cnt", done_cnt, 5);
      // fill TX with enable low, hold tx_valid while full
      gap_cfg = 0; clk_div_cfg = 0; enable = 0; rx_ready = 0;
      for (int i = 0; i < 8; i++) push(8'h10 + 8'(i), 16'd4, 1);
      tx_data = 8'hEE; tx_valid = 1;
      tick(3);
      check("full_tx_ready", tx_ready, 0);
      check("full_tx_level", tx_level, 8);
      tx_valid = 0;
      enable = 1;
      exp_irq.push_back(13);
      wait_drain("fill_done", 2000);
      check("rx_full_level", rx_level, 8);
      push(8'h18, 16'd4, 1);
      exp_irq.push_back(14);
      tick(20);
      check("stall_busy", busy, 0);
      check("stall_tx_level", tx_level, 1);
      check("stall_rx_level", rx_level, 8);
      rx_ready = 1;
      tick(1);
      rx_ready = 0;
      wait_drain("stall_resume", 500);
      check("resume_rx_level", rx_level, 8);
      rx_ready = 1;
      wait_drain("rx_drain", 100);
      check("drain_rx_level", rx_level, 0);
      // timeout on a hung master, next byte still goes out
      hang = 1;
      push(8'h5A, 16'd4, 0);
      push(8'h77, 16'd4, 1);
      exp_irq.push_back(15);
      wait_drain("timeout_done", 1000);
      check("timeout_flag", timeout_err, 1);
      check("timeout_done_cnt", done_cnt, 15);
      check("timeout_rx_level", rx_level, 0);
      err_clr = 1;
      tick(1);
      err_clr = 0;
      check("err_clr", timeout_err, 0);
      // divider: default for zero config, then explicit 10
      push(8'h11, 16'd4, 1);
      wait_start("div_first");
      clk_div_cfg = 10;
      push(8'h22, 16'd10, 1);
      exp_irq.push_back(17);
      wait_drain("div_done", 500);
      check("sb_empty", exp_start.size() + exp_rx.size() + exp_irq.size(), 0);
      // reset while waiting on the master with three bytes queued
      for (int i = 0; i < 4; i++) push(8'h31 + 8'(i), 16'd10, 1);
      n = 0;
      while (!(m_busy && !m_start) && n < 200) begin @(negedge clk); n++; end
      check("reach_wait", int'(n < 200), 1);
      tick(5);
      reset = 1;
      exp_start.delete(); exp_rx.delete(); exp_irq.delete();
      tick(1);
      check_reset_outputs("midrst");
      tick(1);
      reset = 0;
      tick(60);
      check("post_reset_busy", busy, 0);
      check("post_reset_irq_none", exp_irq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
